// File: rtl/gray2rgba_pkg.sv
// Shared widths and pixel type for the sobel output converter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package sobel_pkg;

   localparam int LINE_W        = 512;
   localparam int GRAY_W        = 8;
   localparam int PIX_W         = 32;
   localparam int GRAY_PER_LINE = LINE_W / GRAY_W;              // 64
   localparam int PIX_PER_LINE  = LINE_W / PIX_W;               // 16
   localparam int BEATS         = GRAY_PER_LINE / PIX_PER_LINE; // 4
   localparam int SLICE_W       = PIX_PER_LINE * GRAY_W;        // gray bits per output beat

   // Field order puts alpha in the top byte and red in the bottom byte.
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } rgba_t;

   // Replicate one gray sample into R, G and B, optionally inverted.
   function automatic rgba_t expand_gray(input logic [7:0] s,
                                         input logic [7:0] alpha,
                                         input bit         invert);
      logic [7:0] v;
      v = invert ? (8'hFF - s) : s;
      return '{a: alpha, b: v, g: v, r: v};
   endfunction

endpackage

// File: rtl/gray2rgba_if.sv
// Handshake bundle around gray2rgba: gray line stream in, RGBA beat stream out.
// Latency: n/a (wires only).
// Backpressure: ready_in / ready_out carry backpressure in each direction.
// Ports: data_in/valid_in/ready_in (gray side), data_out/valid_out/ready_out (RGBA side).
interface gray2rgba_if;
   import sobel_pkg::*;

   logic [LINE_W-1:0] data_in;
   logic              valid_in;
   logic              ready_in;
   logic [LINE_W-1:0] data_out;
   logic              valid_out;
   logic              ready_out;

   // master: the environment that feeds gray lines and drains RGBA beats.
   modport master (
      output data_in, valid_in, ready_out,
      input  ready_in, data_out, valid_out
   );

   // slave: the converter itself.
   modport slave (
      input  data_in, valid_in, ready_out,
      output ready_in, data_out, valid_out
   );

endinterface

// File: rtl/gray2rgba_expand.sv
// Combinational expansion of 16 gray samples into 16 RGBA pixels.
// Latency: 0 cycles (pure logic).
// Backpressure: none; caller owns all flow control.
// Ports: gray (16 x 8-bit samples, sample i at [8i+7:8i]), pix (16 x rgba_t, pixel i at [32i+31:32i]).
module gray_expand
   import sobel_pkg::*;
#(
   parameter logic [7:0] ALPHA  = 8'hFF,
   parameter bit         INVERT = 1'b0
) (
   input  logic [SLICE_W-1:0]           gray,
   output rgba_t [PIX_PER_LINE-1:0]     pix
);

   for (genvar i = 0; i < PIX_PER_LINE; i++) begin : g_pix
      assign pix[i] = expand_gray(gray[GRAY_W*i +: GRAY_W], ALPHA, INVERT);
   end

endmodule

// File: rtl/gray2rgba.sv
// Gearbox: one 64-sample gray line in, four 16-pixel RGBA beats out.
// Latency: first beat valid the cycle after accept; 1 line per 4 cycles sustained.
// Backpressure: beats hold while ready_out=0; ready_in only when buffer empty or last beat leaving.
// Ports: clk, rst_b (async active-low), bus (gray2rgba_if.slave: data/valid/ready in and out).
module gray2rgba
   import sobel_pkg::*;
#(
   parameter logic [7:0] ALPHA  = 8'hFF,
   parameter bit         INVERT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_b,
   gray2rgba_if.slave  bus
);

   // Buffer viewed as one gray slice per output beat, so the beat counter indexes it directly.
   logic [BEATS-1:0][SLICE_W-1:0] buf_data;
   logic                          buf_valid;
   logic [1:0]                    beat;

   logic                          last_beat;
   logic                          accept;
   logic                          xfer;
   rgba_t [PIX_PER_LINE-1:0]      pix;

   assign last_beat = (beat == 2'd3);

   // Refill is allowed in the same cycle the last beat leaves, which keeps lines gapless.
   // Deliberately independent of valid_in.
   assign bus.ready_in  = !buf_valid || (last_beat && bus.ready_out);
   assign bus.valid_out = buf_valid;

   assign accept = bus.valid_in && bus.ready_in;
   assign xfer   = buf_valid && bus.ready_out;

   gray_expand #(
      .ALPHA  (ALPHA),
      .INVERT (INVERT)
   ) u_expand (
      .gray (buf_data[beat]),
      .pix  (pix)
   );

   // Output comes only from registered state; forced to zero when idle.
   assign bus.data_out = buf_valid ? pix : '0;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         buf_data  <= '0;
         buf_valid <= 1'b0;
         beat      <= 2'd0;
      end else if (accept) begin
         // Also covers the last-beat-plus-refill case: the new line takes over.
         buf_data  <= bus.data_in;
         buf_valid <= 1'b1;
         beat      <= 2'd0;
      end else if (xfer) begin
         if (last_beat) begin
            buf_valid <= 1'b0;
            beat      <= 2'd0;
         end else begin
            beat      <= beat + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_gray2rgba.sv
module tb_gray2rgba;
   import sobel_pkg::*;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   gray2rgba_if bus ();
   gray2rgba_if bus_inv ();

   gray2rgba u_dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   gray2rgba #(.ALPHA(8'h80), .INVERT(1'b1)) u_inv (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_inv)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference: beat k of a line is pixels from samples 16k..16k+15, each {alpha, v, v, v}.
   function automatic logic [511:0] exp_beat(input logic [511:0] line, input int k,
                                             input logic [7:0] alpha, input bit inv);
      logic [511:0] r;
      logic [7:0]   s;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         s = line[8*(16*k+i) +: 8];
         if (inv) s = 8'd255 - s;
         r[32*i +: 32] = {alpha, s, s, s};
      end
      return r;
   endfunction

   function automatic logic [511:0] rand_line();
      logic [511:0] r;
      for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   task automatic idle_all();
      bus.valid_in      = 1'b0;
      bus.data_in       = '0;
      bus.ready_out     = 1'b1;
      bus_inv.valid_in  = 1'b0;
      bus_inv.data_in   = '0;
      bus_inv.ready_out = 1'b1;
   endtask

   task automatic test_reset();
      idle_all();
      rst_b = 1'b0;
      #2;
      n_chk++;
      if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b want 0", bus.valid_out); end
      n_chk++;
      if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
      n_chk++;
      if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b want 1", bus.ready_in); end
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [511:0] line;
      logic [511:0] e;
      for (int j = 0; j < 64; j++) line[8*j +: 8] = 8'(j);
      bus.data_in = line; bus.valid_in = 1'b1; bus.ready_out = 1'b1;
      #1;
      n_chk++;
      if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL single_accept: ready_in got %b want 1", bus.ready_in); end
      @(negedge clk);
      bus.valid_in = 1'b0; bus.data_in = '0;
      for (int c = 1; c <= 6; c++) begin
         #1;
         n_chk++;
         if (bus.valid_out !== (c <= 4)) begin
            n_fail++; $display("FAIL single_valid c=%0d: got %b want %b", c, bus.valid_out, (c <= 4));
         end
         if (c <= 4) begin
            e = exp_beat(line, c - 1, 8'hFF, 1'b0);
            n_chk++;
            if (bus.data_out !== e) begin n_fail++; $display("FAIL single_beat%0d: got %h want %h", c - 1, bus.data_out, e); end
         end
         if (c == 2) begin
            n_chk++;
            if (bus.data_out[31:0] !== 32'hFF101010) begin
               n_fail++; $display("FAIL single_b1p0: got %h want ff101010", bus.data_out[31:0]);
            end
         end
         if (c == 4) begin
            n_chk++;
            if (bus.data_out[511:480] !== 32'hFF3F3F3F) begin
               n_fail++; $display("FAIL single_b3p15: got %h want ff3f3f3f", bus.data_out[511:480]);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [511:0] a, b, e;
      logic         b_acc;
      a = {64{8'h11}};
      b = {64{8'h22}};
      bus.data_in = a; bus.valid_in = 1'b1; bus.ready_out = 1'b1;
      #1;
      n_chk++;
      if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_a: ready_in got %b want 1", bus.ready_in); end
      @(negedge clk);
      b_acc = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         bus.valid_in = !b_acc;
         bus.data_in  = b_acc ? '0 : b;
         #1;
         e = (c <= 4) ? {16{32'hFF111111}} : {16{32'hFF222222}};
         n_chk++;
         if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b want 1", c, bus.valid_out); end
         n_chk++;
         if (bus.data_out !== e) begin n_fail++; $display("FAIL b2b_data c=%0d: got %h want %h", c, bus.data_out, e); end
         if (c <= 4) begin
            n_chk++;
            if (bus.ready_in !== (c == 4)) begin
               n_fail++; $display("FAIL b2b_ready_in c=%0d: got %b want %b", c, bus.ready_in, (c == 4));
            end
         end
         if (bus.valid_in && bus.ready_in) b_acc = 1'b1;
         @(negedge clk);
      end
      bus.valid_in = 1'b0; bus.data_in = '0;
      #1;
      n_chk++;
      if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: valid_out got %b want 0", bus.valid_out); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [511:0] l, cl, e;
      logic         c_acc;
      l  = rand_line();
      cl = rand_line();
      bus.data_in = l; bus.valid_in = 1'b1; bus.ready_out = 1'b1;
      #1;
      n_chk++;
      if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL bp_accept: ready_in got %b want 1", bus.ready_in); end
      @(negedge clk);
      c_acc = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         bus.ready_out = !(c >= 3 && c <= 7);
         bus.valid_in  = !c_acc;
         bus.data_in   = c_acc ? '0 : cl;
         #1;
         if (c <= 2)      e = exp_beat(l, c - 1, 8'hFF, 1'b0);
         else if (c <= 8) e = exp_beat(l, 2, 8'hFF, 1'b0);
         else if (c == 9) e = exp_beat(l, 3, 8'hFF, 1'b0);
         else             e = exp_beat(cl, c - 10, 8'hFF, 1'b0);
         n_chk++;
         if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d: got %b want 1", c, bus.valid_out); end
         n_chk++;
         if (bus.data_out !== e) begin n_fail++; $display("FAIL bp_data c=%0d: got %h want %h", c, bus.data_out, e); end
         if (c >= 3 && c <= 8) begin
            n_chk++;
            if (bus.ready_in !== 1'b0) begin n_fail++; $display("FAIL bp_ready_in_low c=%0d: got %b want 0", c, bus.ready_in); end
         end
         if (c == 9) begin
            n_chk++;
            if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL bp_ready_in_beat3: got %b want 1", bus.ready_in); end
         end
         if (bus.valid_in && bus.ready_in) c_acc = 1'b1;
         @(negedge clk);
      end
      idle_all();
      #1;
      n_chk++;
      if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_idle: valid_out got %b want 0", bus.valid_out); end
      @(negedge clk);
   endtask

   task automatic test_invert();
      logic [511:0] l, e;
      l = rand_line();
      l[7:0] = 8'h00;
      bus_inv.data_in = l; bus_inv.valid_in = 1'b1; bus_inv.ready_out = 1'b1;
      #1;
      n_chk++;
      if (bus_inv.ready_in !== 1'b1) begin n_fail++; $display("FAIL inv_accept: ready_in got %b want 1", bus_inv.ready_in); end
      @(negedge clk);
      bus_inv.valid_in = 1'b0; bus_inv.data_in = '0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         e = exp_beat(l, c - 1, 8'h80, 1'b1);
         n_chk++;
         if (bus_inv.valid_out !== 1'b1) begin n_fail++; $display("FAIL inv_valid c=%0d: got %b want 1", c, bus_inv.valid_out); end
         n_chk++;
         if (bus_inv.data_out !== e) begin n_fail++; $display("FAIL inv_beat%0d: got %h want %h", c - 1, bus_inv.data_out, e); end
         if (c == 1) begin
            n_chk++;
            if (bus_inv.data_out[31:0] !== 32'h80FFFFFF) begin
               n_fail++; $display("FAIL inv_b0p0: got %h want 80ffffff", bus_inv.data_out[31:0]);
            end
         end
         @(negedge clk);
      end
      #1;
      n_chk++;
      if (bus_inv.valid_out !== 1'b0) begin n_fail++; $display("FAIL inv_idle: valid_out got %b want 0", bus_inv.valid_out); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [511:0] l, m, e;
      l = rand_line();
      m = rand_line();
      bus.data_in = l; bus.valid_in = 1'b1; bus.ready_out = 1'b1;
      @(negedge clk);
      bus.valid_in = 1'b0; bus.data_in = '0;
      @(negedge clk);
      #1;
      e = exp_beat(l, 1, 8'hFF, 1'b0);
      n_chk++;
      if (bus.data_out !== e) begin n_fail++; $display("FAIL rmid_pre_beat1: got %h want %h", bus.data_out, e); end
      rst_b = 1'b0;
      #1;
      n_chk++;
      if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_out: got %b want 0", bus.valid_out); end
      n_chk++;
      if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_in: got %b want 1", bus.ready_in); end
      n_chk++;
      if (bus.data_out !== '0) begin n_fail++; $display("FAIL rmid_data_out: got %h want 0", bus.data_out); end
      @(negedge clk);
      rst_b = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         n_chk++;
         if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_no_leftover c=%0d: got %b want 0", c, bus.valid_out); end
         @(negedge clk);
      end
      bus.data_in = m; bus.valid_in = 1'b1;
      #1;
      n_chk++;
      if (bus.ready_in !== 1'b1) begin n_fail++; $display("FAIL rmid_accept_new: ready_in got %b want 1", bus.ready_in); end
      @(negedge clk);
      bus.valid_in = 1'b0; bus.data_in = '0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         e = exp_beat(m, c - 1, 8'hFF, 1'b0);
         n_chk++;
         if (bus.valid_out !== 1'b1 || bus.data_out !== e) begin
            n_fail++; $display("FAIL rmid_new_beat%0d: valid %b data %h want valid 1 data %h", c - 1, bus.valid_out, bus.data_out, e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [511:0] exp_q[$];
      logic [511:0] cur, prev_data, e;
      logic         offering, prev_stall;
      int           lines_in, beats_out, budget;
      lines_in = 0; beats_out = 0; offering = 1'b0; prev_stall = 1'b0; prev_data = '0;
      cur = '0; budget = 0;
      while (beats_out < 4000 && budget < 60000) begin
         budget++;
         if (!offering && lines_in < 1000 && $urandom_range(0, 3) != 0) begin
            cur = rand_line();
            offering = 1'b1;
         end
         bus.valid_in  = offering;
         bus.data_in   = offering ? cur : '0;
         bus.ready_out = ($urandom_range(0, 2) != 0);
         #1;
         if (prev_stall) begin
            n_chk++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== prev_data) begin
               n_fail++; $display("FAIL rnd_stall_hold: valid %b data %h want valid 1 data %h", bus.valid_out, bus.data_out, prev_data);
            end
         end
         if (bus.valid_out && bus.ready_out) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rnd_unexpected_beat: got %h want no beat", bus.data_out);
            end else begin
               e = exp_q.pop_front();
               if (bus.data_out !== e) begin
                  n_fail++; $display("FAIL rnd_data beat=%0d: got %h want %h", beats_out, bus.data_out, e);
               end
            end
            beats_out++;
         end
         if (bus.valid_in && bus.ready_in) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(exp_beat(cur, k, 8'hFF, 1'b0));
            lines_in++;
            offering = 1'b0;
         end
         prev_stall = bus.valid_out && !bus.ready_out;
         prev_data  = bus.data_out;
         @(negedge clk);
      end
      idle_all();
      n_chk++;
      if (lines_in != 1000) begin n_fail++; $display("FAIL rnd_lines_accepted: got %0d want 1000", lines_in); end
      n_chk++;
      if (beats_out != 4 * lines_in) begin n_fail++; $display("FAIL rnd_beat_count: got %0d want %0d", beats_out, 4 * lines_in); end
      n_chk++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d pending want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_invert();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
